// File: rtl/window_sum_accumulator.sv
// Streaming 5x5 window sum: one column of five samples arrives per valid beat,
// column sums are registered in stage 1, accumulated in stage 2, and the
// completed window total is presented with a one-cycle o_valid pulse.
module window_sum_accumulator #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SUM_W  = DATA_W + 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic              i_first,
  input  logic [DATA_W-1:0] c0,
  input  logic [DATA_W-1:0] c1,
  input  logic [DATA_W-1:0] c2,
  input  logic [DATA_W-1:0] c3,
  input  logic [DATA_W-1:0] c4,
  output logic [SUM_W-1:0]  o_sum,
  output logic              o_valid,
  output logic              o_busy,
  output logic              o_err
);

  // Five samples of DATA_W bits need three extra bits to avoid truncation.
  localparam int unsigned COL_W = DATA_W + 3;

  typedef enum logic {StIdle, StAccum} state_e;

  state_e           state_q, state_d;
  logic [2:0]       col_cnt_q, col_cnt_d;
  logic [COL_W-1:0] col_sum;
  logic             tag_valid, tag_first, tag_last, tag_err;

  logic [COL_W-1:0] s1_sum_q;
  logic             s1_valid_q, s1_first_q, s1_last_q, s1_err_q;
  logic [SUM_W-1:0] acc_q;
  logic             s2_last_q, s2_err_q;
  logic [SUM_W-1:0] o_sum_q;
  logic             o_valid_q, o_err_q;

  // Column sum of the incoming beat, zero-extended before adding.
  always_comb begin
    col_sum = COL_W'(c0) + COL_W'(c1) + COL_W'(c2) + COL_W'(c3) + COL_W'(c4);
  end

  // Window framing: decide whether the beat is accepted and how it is tagged.
  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    tag_valid = 1'b0;
    tag_first = 1'b0;
    tag_last  = 1'b0;
    tag_err   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          if (i_first) begin
            state_d   = StAccum;
            col_cnt_d = 3'd1;
            tag_valid = 1'b1;
            tag_first = 1'b1;
          end else begin
            // Column with no window open: drop it and flag the violation.
            tag_err = 1'b1;
          end
        end
      end
      StAccum: begin
        if (i_valid) begin
          tag_valid = 1'b1;
          if (i_first) begin
            // Early restart: the new beat reloads the accumulator, so the
            // partial window vanishes without ever raising o_valid.
            tag_first = 1'b1;
            tag_err   = 1'b1;
            col_cnt_d = 3'd1;
          end else if (col_cnt_q == 3'd4) begin
            tag_last  = 1'b1;
            col_cnt_d = 3'd0;
            state_d   = StIdle;
          end else begin
            col_cnt_d = col_cnt_q + 3'd1;
          end
        end
      end
      default: begin
        state_d   = StIdle;
        col_cnt_d = 3'd0;
      end
    endcase
  end

  // FSM state and column counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      col_cnt_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
    end
  end

  // Stage 1: register column sum and beat tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sum_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_err_q   <= 1'b0;
    end else begin
      if (i_valid) begin
        s1_sum_q <= col_sum;
      end
      s1_valid_q <= tag_valid;
      s1_first_q <= tag_first;
      s1_last_q  <= tag_last;
      s1_err_q   <= tag_err;
    end
  end

  // Stage 2: window accumulator; a first-tagged beat reloads it.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      s2_last_q <= 1'b0;
      s2_err_q  <= 1'b0;
    end else begin
      if (s1_valid_q) begin
        acc_q <= s1_first_q ? SUM_W'(s1_sum_q) : acc_q + SUM_W'(s1_sum_q);
      end
      s2_last_q <= s1_valid_q & s1_last_q;
      s2_err_q  <= s1_err_q;
    end
  end

  // Output register: capture completed window total, pulse valid/err.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_sum_q   <= '0;
      o_valid_q <= 1'b0;
      o_err_q   <= 1'b0;
    end else begin
      if (s2_last_q) begin
        o_sum_q <= acc_q;
      end
      o_valid_q <= s2_last_q;
      o_err_q   <= s2_err_q;
    end
  end

  assign o_sum   = o_sum_q;
  assign o_valid = o_valid_q;
  assign o_err   = o_err_q;
  assign o_busy  = (state_q == StAccum);

endmodule
